// File: rtl/delta2_backprop.sv
// Hidden-layer error unit: delta2_j = (sum_k w3_kj * delta3_k) * dadz2_j in signed Q5.10.
// The beats are taken serially. The scale/saturate runs in two registered steps, and the result goes out on a valid/ready port.
module delta2_backprop #(
   parameter int N_OUT = 3,
   parameter int DW    = 16,
   parameter int FRAC  = 10
) (
   input  logic          clk,
   input  logic          res,
   input  logic          start_i,
   input  logic [DW-1:0] dadz2_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] delta3_i,
   input  logic [DW-1:0] w3_i,
   output logic [DW-1:0] delta2_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic          busy_o,
   output logic          sat_o
);

   // Accumulator is wide enough for N_OUT full-width products plus sign, so it never wraps.
   localparam int ACC_W = 2*DW + $clog2(N_OUT) + 1;
   localparam int CW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N_OUT - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACC    = 3'd1,
      SCALE1 = 3'd2,
      SCALE2 = 3'd3,
      OUT    = 3'd4
   } state_t;

   // Clamp a wide signed value to DW bits; the MSB of the return value flags a clamp.
   function automatic logic [DW:0] sat_fn(input logic signed [ACC_W-1:0] v);
      logic [DW:0] r;
      if (v > SAT_MAX) begin
         r = {1'b1, SAT_MAX[DW-1:0]};
      end else if (v < SAT_MIN) begin
         r = {1'b1, SAT_MIN[DW-1:0]};
      end else begin
         r = {1'b0, v[DW-1:0]};
      end
      return r;
   endfunction

   state_t                    state_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic        [CW-1:0]      cnt_r;
   logic signed [DW-1:0]      dadz2_r;
   logic signed [DW-1:0]      s_r;
   logic        [DW-1:0]      delta2_r;
   logic                      out_valid_r;
   logic                      sat_r;

   logic signed [2*DW-1:0]    prod_s;
   logic signed [ACC_W-1:0]   prod_ext_s;
   logic signed [ACC_W-1:0]   acc_shift_s;
   logic        [DW:0]        sat1_s;
   logic signed [2*DW-1:0]    scale_p_s;
   logic signed [ACC_W-1:0]   scale_ext_s;
   logic signed [ACC_W-1:0]   scale_shift_s;
   logic        [DW:0]        sat2_s;

   assign prod_s        = $signed(delta3_i) * $signed(w3_i);
   assign prod_ext_s    = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
   assign acc_shift_s   = acc_r >>> FRAC;
   assign sat1_s        = sat_fn(acc_shift_s);
   assign scale_p_s     = s_r * dadz2_r;
   assign scale_ext_s   = {{(ACC_W-2*DW){scale_p_s[2*DW-1]}}, scale_p_s};
   assign scale_shift_s = scale_ext_s >>> FRAC;
   assign sat2_s        = sat_fn(scale_shift_s);

   // Handshake and status flags come straight from the state register.
   assign in_ready_o  = (state_r == ACC);
   assign busy_o      = (state_r != IDLE);
   assign delta2_o    = delta2_r;
   assign out_valid_o = out_valid_r;
   assign sat_o       = sat_r;

   // Operation sequencer: accumulate, rescale, scale by dadz2, then hold until taken.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         cnt_r       <= '0;
         dadz2_r     <= '0;
         s_r         <= '0;
         delta2_r    <= '0;
         out_valid_r <= 1'b0;
         sat_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  dadz2_r <= $signed(dadz2_i);
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  sat_r   <= 1'b0;
                  state_r <= ACC;
               end
            end
            ACC: begin
               if (in_valid_i) begin
                  acc_r <= acc_r + prod_ext_s;
                  if (cnt_r == CNT_LAST) begin
                     cnt_r   <= '0;
                     state_r <= SCALE1;
                  end else begin
                     cnt_r <= cnt_r + CW'(1'b1);
                  end
               end
            end
            SCALE1: begin
               s_r     <= $signed(sat1_s[DW-1:0]);
               sat_r   <= sat_r | sat1_s[DW];
               state_r <= SCALE2;
            end
            SCALE2: begin
               delta2_r    <= sat2_s[DW-1:0];
               sat_r       <= sat_r | sat2_s[DW];
               out_valid_r <= 1'b1;
               state_r     <= OUT;
            end
            OUT: begin
               if (out_ready_i) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule
